// File: rtl/jpeg_pkg.sv
// Shared JPEG definitions: block geometry, zig-zag scan table and the
// reorder buffer's read-side state encoding.
package jpeg_pkg;

  localparam int BLK_SIZE = 64;

  typedef logic [5:0] blk_idx_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Zig-zag position k -> raster index (8*row + col).
  localparam blk_idx_t ZZ_LUT [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zz_mem.sv
// Two-bank 64x8 coefficient store: one synchronous write port and one
// read port with registered output data.
module zz_mem
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       wr_en,
  input  logic       wr_bank,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic       rd_bank,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [2*BLK_SIZE];
  logic [7:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto plain RAM; only the output
  // register, which the consumer can observe, is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data_q <= 8'd0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[{rd_bank, rd_addr}];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/zigzag_buf.sv
// Ping-pong raster-to-zig-zag reorder buffer: fills one bank while the other
// is drained as a gapless 64-cycle burst.
module zigzag_buf
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid
);

  logic       wbank_q, wbank_d;
  logic       rbank_q, rbank_d;
  blk_idx_t   wcnt_q, wcnt_d;
  blk_idx_t   rcnt_q, rcnt_d;
  logic [1:0] bank_full_q, bank_full_d;
  rd_state_e  state_q, state_d;
  logic       dout_valid_q;

  logic wr_fire, wr_last, rd_en, rd_last;

  assign din_ready = ~bank_full_q[wbank_q];
  assign wr_fire   = din_valid & din_ready;
  assign wr_last   = wr_fire & (wcnt_q == 6'd63);
  assign rd_en     = (state_q == RD_READ);
  assign rd_last   = rd_en & (rcnt_q == 6'd63);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    wcnt_d      = wcnt_q;
    wbank_d     = wbank_q;
    rcnt_d      = rcnt_q;
    rbank_d     = rbank_q;
    bank_full_d = bank_full_q;
    state_d     = state_q;

    if (wr_fire) begin
      wcnt_d = wcnt_q + 6'd1;
    end
    if (wr_last) begin
      bank_full_d[wbank_q] = 1'b1;
      wbank_d              = ~wbank_q;
    end
    if (rd_en) begin
      rcnt_d = rcnt_q + 6'd1;
    end
    // Set and clear always target different banks, so both apply.
    if (rd_last) begin
      bank_full_d[rbank_q] = 1'b0;
      rbank_d              = ~rbank_q;
    end

    // Looking at bank_full_d lets a bank filling on this edge continue the burst.
    case (state_q)
      RD_IDLE: if (bank_full_d[rbank_d]) state_d = RD_READ;
      RD_READ: if (rd_last && !bank_full_d[rbank_d]) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wcnt_q       <= '0;
      wbank_q      <= 1'b0;
      rcnt_q       <= '0;
      rbank_q      <= 1'b0;
      bank_full_q  <= 2'b00;
      state_q      <= RD_IDLE;
      dout_valid_q <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      wbank_q      <= wbank_d;
      rcnt_q       <= rcnt_d;
      rbank_q      <= rbank_d;
      bank_full_q  <= bank_full_d;
      state_q      <= state_d;
      dout_valid_q <= rd_en;
    end
  end

  zz_mem u_mem (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (wr_fire),
    .wr_bank (wbank_q),
    .wr_addr (wcnt_q),
    .wr_data (din),
    .rd_en   (rd_en),
    .rd_bank (rbank_q),
    .rd_addr (ZZ_LUT[rcnt_q]),
    .rd_data (dout)
  );

  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_zigzag_buf.sv
// Directed bench for zigzag_buf: latency, permutation, back-to-back, sparse,
// partial-block, mid-burst reset and both-banks-full scenarios.
module tb_zigzag_buf;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int zz [64];
  logic [7:0] out_q [$];
  int         t_q   [$];

  always #5 clk = ~clk;

  zigzag_buf dut (
    .clk        (clk),
    .nrst       (nrst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      out_q.push_back(dout);
      t_q.push_back(edge_n);
    end
  end

  // Independent zig-zag walk over anti-diagonals; even sums run upward.
  task automatic build_zz();
    int idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[idx] = 8 * r + (s - r); idx++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[idx] = 8 * r + (s - r); idx++; end
      end
    end
  endtask

  task automatic clear_out();
    out_q.delete();
    t_q.delete();
  endtask

  task automatic feed(input int base, input int n, input bit sparse, output int last_edge,
                      output int rdy_drops);
    rdy_drops = 0;
    for (int i = 0; i < n; i++) begin
      din       = 8'(base + i);
      din_valid = 1'b1;
      if (din_ready !== 1'b1) rdy_drops++;
      @(negedge clk);
      last_edge = edge_n;
      if (sparse) begin
        din_valid = 1'b0;
        @(negedge clk);
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int c = 0;
    while (out_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    din = 8'd0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 8'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", dout); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", dout_valid); end
  endtask

  task automatic test_single_block();
    int e, d;
    int hand [18] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5, 62, 63};
    clear_out();
    feed(0, 64, 1'b0, e, d);
    checks++; if (out_q.size() != 0) begin failures++; $display("FAIL single_early got=%0d exp=0", out_q.size()); end
    wait_out(64, 200);
    checks++;
    if (out_q.size() != 64) begin
      failures++; $display("FAIL single_count got=%0d exp=64", out_q.size());
    end else begin
      for (int k = 0; k < 18; k++) begin
        int p = (k < 16) ? k : k + 46;
        checks++;
        if (out_q[p] !== 8'(hand[k])) begin failures++; $display("FAIL single_hand[%0d] got=%0d exp=%0d", p, out_q[p], hand[k]); end
      end
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (out_q[k] !== 8'(zz[k])) begin failures++; $display("FAIL single_data[%0d] got=%0d exp=%0d", k, out_q[k], zz[k]); end
      end
      checks++; if (t_q[0] != e + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", t_q[0], e + 1); end
      checks++; if (t_q[63] - t_q[0] != 63) begin failures++; $display("FAIL single_gapless got=%0d exp=63", t_q[63] - t_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int e, d;
    clear_out();
    feed(0, 256, 1'b0, e, d);
    checks++; if (d != 0) begin failures++; $display("FAIL b2b_ready_drops got=%0d exp=0", d); end
    wait_out(256, 400);
    checks++;
    if (out_q.size() != 256) begin
      failures++; $display("FAIL b2b_count got=%0d exp=256", out_q.size());
    end else begin
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < 64; k++) begin
          checks++;
          if (out_q[64*b+k] !== 8'(64*b + zz[k])) begin
            failures++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", 64*b+k, out_q[64*b+k], 64*b + zz[k]);
          end
        end
      checks++; if (t_q[255] - t_q[0] != 255) begin failures++; $display("FAIL b2b_gapless got=%0d exp=255", t_q[255] - t_q[0]); end
    end
  endtask

  task automatic test_sparse();
    int e0, e1, d;
    clear_out();
    feed(0, 64, 1'b1, e0, d);
    feed(64, 64, 1'b1, e1, d);
    wait_out(128, 300);
    checks++;
    if (out_q.size() != 128) begin
      failures++; $display("FAIL sparse_count got=%0d exp=128", out_q.size());
    end else begin
      checks++; if (t_q[0] != e0 + 1) begin failures++; $display("FAIL sparse_start0 got=%0d exp=%0d", t_q[0], e0 + 1); end
      checks++; if (t_q[64] != e1 + 1) begin failures++; $display("FAIL sparse_start1 got=%0d exp=%0d", t_q[64], e1 + 1); end
      checks++; if (t_q[63] - t_q[0] != 63) begin failures++; $display("FAIL sparse_gapless0 got=%0d exp=63", t_q[63] - t_q[0]); end
      checks++; if (t_q[127] - t_q[64] != 63) begin failures++; $display("FAIL sparse_gapless1 got=%0d exp=63", t_q[127] - t_q[64]); end
      for (int k = 0; k < 128; k++) begin
        checks++;
        if (out_q[k] !== 8'(64*(k/64) + zz[k%64])) begin
          failures++; $display("FAIL sparse_data[%0d] got=%0d exp=%0d", k, out_q[k], 64*(k/64) + zz[k%64]);
        end
      end
    end
  endtask

  task automatic test_partial();
    int e, d;
    clear_out();
    feed(0, 40, 1'b0, e, d);
    repeat (200) @(negedge clk);
    checks++; if (out_q.size() != 0) begin failures++; $display("FAIL partial_held got=%0d exp=0", out_q.size()); end
    feed(40, 24, 1'b0, e, d);
    wait_out(64, 200);
    checks++;
    if (out_q.size() != 64) begin
      failures++; $display("FAIL partial_count got=%0d exp=64", out_q.size());
    end else begin
      checks++; if (t_q[0] != e + 1) begin failures++; $display("FAIL partial_latency got=%0d exp=%0d", t_q[0], e + 1); end
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (out_q[k] !== 8'(zz[k])) begin failures++; $display("FAIL partial_data[%0d] got=%0d exp=%0d", k, out_q[k], zz[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e, d, c;
    clear_out();
    force dut.rd_en = 1'b0;
    feed(0, 64, 1'b0, e, d);
    feed(64, 32, 1'b0, e, d);
    release dut.rd_en;
    c = 0;
    while (out_q.size() < 20 && c < 200) begin @(negedge clk); c++; end
    checks++; if (out_q.size() < 20) begin failures++; $display("FAIL rstmid_burst got=%0d exp=20", out_q.size()); end
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", dout_valid); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL rstmid_async_valid got=%b exp=0", dout_valid); end
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", din_ready); end
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    clear_out();
    feed(100, 64, 1'b0, e, d);
    wait_out(64, 200);
    repeat (100) @(negedge clk);
    checks++;
    if (out_q.size() != 64) begin
      failures++; $display("FAIL rstmid_count got=%0d exp=64", out_q.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (out_q[k] !== 8'(100 + zz[k])) begin failures++; $display("FAIL rstmid_data[%0d] got=%0d exp=%0d", k, out_q[k], 100 + zz[k]); end
      end
    end
  endtask

  task automatic test_both_full();
    int e, d;
    clear_out();
    force dut.rd_en = 1'b0;
    feed(0, 128, 1'b0, e, d);
    checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", din_ready); end
    din = 8'hEE;
    din_valid = 1'b1;
    repeat (10) @(negedge clk);
    din_valid = 1'b0;
    checks++; if (out_q.size() != 0) begin failures++; $display("FAIL full_held got=%0d exp=0", out_q.size()); end
    release dut.rd_en;
    wait_out(128, 300);
    checks++;
    if (out_q.size() != 128) begin
      failures++; $display("FAIL full_count got=%0d exp=128", out_q.size());
    end else begin
      for (int k = 0; k < 128; k++) begin
        checks++;
        if (out_q[k] !== 8'(64*(k/64) + zz[k%64])) begin
          failures++; $display("FAIL full_data[%0d] got=%0d exp=%0d", k, out_q[k], 64*(k/64) + zz[k%64]);
        end
      end
      checks++; if (t_q[127] - t_q[0] != 127) begin failures++; $display("FAIL full_gapless got=%0d exp=127", t_q[127] - t_q[0]); end
    end
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after got=%b exp=1", din_ready); end
  endtask

  initial begin
    build_zz();
    @(negedge clk);
    test_reset();
    test_single_block();
    test_back_to_back();
    test_sparse();
    test_partial();
    test_reset_mid();
    test_both_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
